// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared types and segment constants for the seven-segment scanner
package seven_seg_pkg;

    typedef logic [1:0] digit_idx_t;

    localparam logic [0:6] SEG_OFF  = 7'b1111111;
    localparam logic [0:3] DISP_OFF = 4'b1111;

    // Active-low segments a..g at bit positions 0..6
    localparam logic [0:6] HEX_SEG [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

endpackage

// File: rtl/seven_seg_decoder.sv
// rtl/seven_seg_decoder.sv - nibble to active-low segment pattern
module seven_seg_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [0:6] o_segments
);

    always_comb begin
        o_segments = HEX_SEG[i_nibble];
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - four-digit multiplexed hex display driver with dead time and leading-zero blanking
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int DOT_POS      = 4
) (
    input  logic        clk,
    input  logic        i_reset,
    input  logic [0:15] i_value,
    input  logic        i_load,
    input  logic        i_blank_lz,
    output logic [0:6]  o_segment_enable,
    output logic [0:3]  o_display_enable,
    output logic        o_dot_enable
);

    localparam int            PW          = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] PRESC_BLANK = PW'(BLANK_CYCLES);

    logic [0:15]   latch_q, latch_d;
    logic [PW-1:0] presc_q, presc_d;
    digit_idx_t    idx_q, idx_d;
    logic [0:6]    seg_q, seg_d;
    logic [0:3]    disp_q, disp_d;
    logic          dot_q, dot_d;

    logic          boundary;
    logic [3:0]    nibble;
    logic [0:6]    dec_seg;
    logic [0:3]    zero_prefix;
    logic          lz_blank;

    always_comb begin
        boundary = (presc_q == PRESC_LAST);
        latch_d  = i_load ? i_value : latch_q;
        presc_d  = boundary ? '0 : presc_q + 1'b1;
        idx_d    = boundary ? idx_q + 1'b1 : idx_q;
    end

    always_comb begin
        nibble = latch_q[0:3];
        case (idx_q)
            2'd1:    nibble = latch_q[4:7];
            2'd2:    nibble = latch_q[8:11];
            2'd3:    nibble = latch_q[12:15];
            default: nibble = latch_q[0:3];
        endcase
    end

    // A digit is a leading zero when it and every more significant digit are zero
    always_comb begin
        zero_prefix[0] = (latch_q[0:3] == 4'h0);
        zero_prefix[1] = zero_prefix[0] && (latch_q[4:7] == 4'h0);
        zero_prefix[2] = zero_prefix[1] && (latch_q[8:11] == 4'h0);
        zero_prefix[3] = zero_prefix[2] && (latch_q[12:15] == 4'h0);
        lz_blank       = i_blank_lz && (idx_q != 2'd3) && zero_prefix[idx_q];
    end

    seven_seg_decoder u_decoder (
        .i_nibble   (nibble),
        .o_segments (dec_seg)
    );

    always_comb begin
        seg_d  = SEG_OFF;
        disp_d = DISP_OFF;
        dot_d  = 1'b1;
        if ((presc_q >= PRESC_BLANK) && !lz_blank) begin
            seg_d         = dec_seg;
            disp_d[idx_q] = 1'b0;
            dot_d         = (int'(idx_q) != DOT_POS);
        end
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            latch_q <= '0;
            presc_q <= '0;
            idx_q   <= '0;
            seg_q   <= SEG_OFF;
            disp_q  <= DISP_OFF;
            dot_q   <= 1'b1;
        end else begin
            latch_q <= latch_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            disp_q  <= disp_d;
            dot_q   <= dot_d;
        end
    end

    assign o_segment_enable = seg_q;
    assign o_display_enable = disp_q;
    assign o_dot_enable     = dot_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb/tb_seven_seg_scanner.sv - directed self-checking bench for seven_seg_scanner
module tb_seven_seg_scanner;

    logic        clk;
    logic        i_reset;
    logic [0:15] i_value;
    logic        i_load;
    logic        i_blank_lz;
    logic [0:6]  o_segment_enable;
    logic [0:3]  o_display_enable;
    logic        o_dot_enable;

    int n_tests;
    int n_fail;

    int         en_cnt [4];
    int         dot_cnt [4];
    logic [0:6] seg_seen [4];
    int         seg_bad;
    int         dark_seg_bad;
    int         dot_dark;
    int         multi;
    int         seq_err;

    seven_seg_scanner #(
        .SCAN_DIV     (8),
        .BLANK_CYCLES (2),
        .DOT_POS      (1)
    ) dut (
        .clk              (clk),
        .i_reset          (i_reset),
        .i_value          (i_value),
        .i_load           (i_load),
        .i_blank_lz       (i_blank_lz),
        .o_segment_enable (o_segment_enable),
        .o_display_enable (o_display_enable),
        .o_dot_enable     (o_dot_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        step(2);
        i_reset = 1'b0;
    endtask

    task automatic do_load(input logic [0:15] v, input logic blz);
        i_value    = v;
        i_blank_lz = blz;
        i_load     = 1'b1;
        step(1);
        i_load     = 1'b0;
    endtask

    task automatic scan(input int n);
        int prev;
        int cur;
        int zeros;
        prev = -1;
        seg_bad = 0; dark_seg_bad = 0; dot_dark = 0; multi = 0; seq_err = 0;
        for (int k = 0; k < 4; k++) begin
            en_cnt[k] = 0; dot_cnt[k] = 0; seg_seen[k] = 7'b1111111;
        end
        repeat (n) begin
            @(negedge clk);
            zeros = 0;
            cur   = -1;
            for (int k = 0; k < 4; k++) begin
                if (!o_display_enable[k]) begin
                    zeros++;
                    cur = k;
                end
            end
            if (zeros > 1) multi++;
            if (zeros == 0) begin
                if (o_segment_enable != 7'b1111111) dark_seg_bad++;
                if (!o_dot_enable) dot_dark++;
            end else if (zeros == 1) begin
                en_cnt[cur]++;
                if (en_cnt[cur] > 1 && seg_seen[cur] != o_segment_enable) seg_bad++;
                seg_seen[cur] = o_segment_enable;
                if (!o_dot_enable) dot_cnt[cur]++;
                if (cur != prev) begin
                    if (prev >= 0 && cur != ((prev + 1) % 4)) seq_err++;
                    prev = cur;
                end
            end
        end
    endtask

    task automatic expect_disp(input string tag, input int k, input int en, input logic [0:6] seg);
        check({tag, "_en"}, en_cnt[k], en);
        if (en > 0) check({tag, "_seg"}, seg_seen[k], seg);
    endtask

    task automatic expect_clean(input string tag);
        check({tag, "_multi"}, multi, 0);
        check({tag, "_segstable"}, seg_bad, 0);
        check({tag, "_darkseg"}, dark_seg_bad, 0);
        check({tag, "_darkdot"}, dot_dark, 0);
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        i_reset    = 1'b1;
        i_value    = '0;
        i_load     = 1'b0;
        i_blank_lz = 1'b0;

        #1;
        check("rst_seg", o_segment_enable, 7'b1111111);
        check("rst_disp", o_display_enable, 4'b1111);
        check("rst_dot", o_dot_enable, 1'b1);

        step(2);
        i_reset = 1'b0;
        step(1);
        check("rel_dark1", o_display_enable, 4'b1111);
        step(1);
        check("rel_dark2", o_display_enable, 4'b1111);
        step(1);
        check("rel_d0_disp", o_display_enable, 4'b0111);
        check("rel_d0_seg", o_segment_enable, 7'b0000001);
        check("rel_d0_dot", o_dot_enable, 1'b1);

        // Edge 16 after release is the slot boundary where index goes 1 -> 2
        step(12);
        i_value = 16'hFFFF;
        i_load  = 1'b1;
        step(1);
        i_load  = 1'b0;
        check("bnd_d1_disp", o_display_enable, 4'b1011);
        check("bnd_d1_seg", o_segment_enable, 7'b0000001);
        check("bnd_d1_dot", o_dot_enable, 1'b0);
        step(1);
        check("bnd_dark1", o_display_enable, 4'b1111);
        step(1);
        check("bnd_dark2", o_display_enable, 4'b1111);
        step(1);
        check("bnd_d2_disp", o_display_enable, 4'b1101);
        check("bnd_d2_seg", o_segment_enable, 7'b0111000);

        do_load(16'h1234, 1'b0);
        scan(32);
        expect_disp("v1234_d0", 0, 6, 7'b1001111);
        expect_disp("v1234_d1", 1, 6, 7'b0010010);
        expect_disp("v1234_d2", 2, 6, 7'b0000110);
        expect_disp("v1234_d3", 3, 6, 7'b1001100);
        check("v1234_dot0", dot_cnt[0], 0);
        check("v1234_dot1", dot_cnt[1], 6);
        check("v1234_dot2", dot_cnt[2], 0);
        check("v1234_dot3", dot_cnt[3], 0);
        expect_clean("v1234");

        do_load(16'h00A5, 1'b1);
        scan(32);
        expect_disp("a5lz_d0", 0, 0, 7'b1111111);
        expect_disp("a5lz_d1", 1, 0, 7'b1111111);
        expect_disp("a5lz_d2", 2, 6, 7'b0001000);
        expect_disp("a5lz_d3", 3, 6, 7'b0100100);
        check("a5lz_dot1", dot_cnt[1], 0);
        expect_clean("a5lz");

        do_load(16'h00A5, 1'b0);
        scan(32);
        expect_disp("a5_d0", 0, 6, 7'b0000001);
        expect_disp("a5_d1", 1, 6, 7'b0000001);
        expect_disp("a5_d2", 2, 6, 7'b0001000);
        expect_disp("a5_d3", 3, 6, 7'b0100100);
        check("a5_dot1", dot_cnt[1], 6);
        expect_clean("a5");

        do_load(16'h0000, 1'b1);
        scan(32);
        expect_disp("z_d0", 0, 0, 7'b1111111);
        expect_disp("z_d1", 1, 0, 7'b1111111);
        expect_disp("z_d2", 2, 0, 7'b1111111);
        expect_disp("z_d3", 3, 6, 7'b0000001);
        expect_clean("z");

        do_load(16'h0A00, 1'b1);
        scan(32);
        expect_disp("a00_d0", 0, 0, 7'b1111111);
        expect_disp("a00_d1", 1, 6, 7'b0001000);
        expect_disp("a00_d2", 2, 6, 7'b0000001);
        expect_disp("a00_d3", 3, 6, 7'b0000001);
        expect_clean("a00");

        // Mid-slot reset while display 2 is lit
        i_blank_lz = 1'b0;
        do_reset();
        do_load(16'h1234, 1'b0);
        step(20);
        check("mid_d2_disp", o_display_enable, 4'b1101);
        check("mid_d2_seg", o_segment_enable, 7'b0000110);
        #2;
        i_reset = 1'b1;
        i_value = 16'h8888;
        i_load  = 1'b1;
        #1;
        check("mid_rst_seg", o_segment_enable, 7'b1111111);
        check("mid_rst_disp", o_display_enable, 4'b1111);
        check("mid_rst_dot", o_dot_enable, 1'b1);
        step(1);
        i_reset = 1'b0;
        i_load  = 1'b0;
        step(1);
        check("mid_dark1", o_display_enable, 4'b1111);
        step(1);
        check("mid_dark2", o_display_enable, 4'b1111);
        step(1);
        check("mid_d0_disp", o_display_enable, 4'b0111);
        check("mid_d0_seg", o_segment_enable, 7'b0000001);

        scan(320);
        check("run_seq", seq_err, 0);
        check("run_d0", en_cnt[0], 60);
        check("run_d1", en_cnt[1], 60);
        check("run_d2", en_cnt[2], 60);
        check("run_d3", en_cnt[3], 60);
        expect_clean("run");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 100000, clock cycles per digit slot (>= 2).
REQ-002 Parameter BLANK_CYCLES, default 1000, dead-time cycles at the start of each slot (< SCAN_DIV).
REQ-003 Parameter DOT_POS, default 4, index of the display whose dot is lit (4 = no dot).
REQ-004 clk  input  1  single system clock; all state on its rising edge.
REQ-005 i_reset  input  1  asynchronous, active-high reset.
REQ-006 i_value  input  [0:15]  four hex digits; bit 0 is MSB; display k shows i_value[4k:4k+3].
REQ-007 i_load  input  1  single-cycle strobe; captures i_value into the display latch.
REQ-008 i_blank_lz  input  1  level; 1 blanks leading-zero digits.
REQ-009 o_segment_enable  output  [0:6]  segments a..g at indices 0..6, active-low (0 = lit).
REQ-010 o_display_enable  output  [0:3]  per-display anode enable, active-low (0 = on).
REQ-011 o_dot_enable  output  1  decimal point, active-low (0 = lit).

Function
REQ-012 The block SHALL hold a 16-bit value latch, loaded from i_value on any clk edge with i_load=1, else held.
REQ-013 A prescaler SHALL count 0..SCAN_DIV-1 and wrap to 0; a slot boundary is the cycle it holds SCAN_DIV-1.
REQ-014 A 2-bit digit index SHALL advance 0->1->2->3->0 on each slot boundary and never otherwise.
REQ-015 All outputs SHALL be registered; each output in cycle n+1 reflects latch, index, prescaler and i_blank_lz in cycle n.
REQ-016 While prescaler < BLANK_CYCLES, o_display_enable SHALL be 4'b1111 and o_segment_enable SHALL be 7'b1111111.
REQ-017 Otherwise exactly one o_display_enable bit SHALL be 0, namely the bit at the digit index.
REQ-018 o_segment_enable SHALL be the active-low hex pattern for the selected nibble: 0-9 and A,b,C,d,E,F; 0 = 0000001, 8 = 0000000, F = 0111000.
REQ-019 With i_blank_lz=1, display k (k<3) SHALL be blanked (its enable stays 1) when nibbles 0..k are all zero; display 3 is never blanked.
REQ-020 o_dot_enable SHALL be 0 only when the digit index equals DOT_POS and the display is enabled; otherwise 1.
REQ-021 i_load in the same cycle as a slot boundary SHALL update the latch and advance the index; the new digit shows the new value.
REQ-022 A latch change SHALL reach the outputs the cycle after the load edge, mid-slot, without restarting the prescaler.
REQ-023 i_value and i_blank_lz are synchronous to clk; no internal synchronizer is required.

Reset
REQ-024 While i_reset=1, regardless of clk: latch = 0, prescaler = 0, index = 0, o_segment_enable = 1111111, o_display_enable = 1111, o_dot_enable = 1.
REQ-025 After release, the first slot SHALL start with prescaler 0 and index 0, including BLANK_CYCLES of dead time.
REQ-026 Reset asserted mid-slot SHALL abort the slot immediately; i_load during reset SHALL be ignored.

Structure
REQ-027 Package seven_seg_pkg SHALL hold the 16-entry hex-to-segment pattern table, the all-off constants SEG_OFF and DISP_OFF, and the digit-index typedef.
REQ-028 Nibble-to-pattern conversion SHALL be a separate combinational sub-module, seven_seg_decoder (4-bit in, 7-bit out), instantiated once.
REQ-029 The block SHALL drive the board's seven-segment outputs and take the counter's low 16 bits as i_value.

Verification (SCAN_DIV=8, BLANK_CYCLES=2, DOT_POS=1)
REQ-030 Reset, then load 0x1234 -> displays 0..3 show 1001111, 0010010, 0000110, 1001100 in turn; each is enabled for 6 cycles after 2 dark cycles, and the dot is lit on display 1 only.
REQ-031 Load 0x00A5 with i_blank_lz=1 -> displays 0 and 1 are never enabled, display 2 shows 0001000 and display 3 shows 0100100; with i_blank_lz=0, displays 0 and 1 show 0000001.
REQ-032 Load 0x0000 with i_blank_lz=1 -> only display 3 is enabled and shows 0000001.
REQ-033 Pulse i_load with 0xFFFF on a slot-boundary cycle -> the index still advances, and the next digit shows 0111000 after its dead time.
REQ-034 Assert i_reset for 1 cycle mid-slot while display 2 is lit -> all outputs go to 1 without waiting for clk; after release, 2 dark cycles follow, then display 0 shows 0000001.
REQ-035 Run 40 slots with no load -> the index sequence is 0,1,2,3 repeating, and no cycle ever has more than one display enable at 0.
